// File: rtl/logic_op_arbiter_pkg.sv
// Shared opcodes, slot states and default width for the logic-op arbiter slice.
package logic_op_arbiter_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_XNOR = 2'b11
  } op_e;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_e;

endpackage

// File: rtl/logic_op_arbiter_unit.sv
// Combinational bitwise logic unit: one gate result per opcode, selected by op.
module logic_unit_8bit
  import logic_op_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] and_y, or_y, xor_y, xnor_y;

  assign and_y  = a & b;
  assign or_y   = a | b;
  assign xor_y  = a ^ b;
  assign xnor_y = ~(a ^ b);

  always_comb begin
    y = and_y;
    case (op_e'(op))
      OP_AND:  y = and_y;
      OP_OR:   y = or_y;
      OP_XOR:  y = xor_y;
      OP_XNOR: y = xnor_y;
      default: y = and_y;
    endcase
  end

endmodule

// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter sharing one logic unit between two requesters, with a
// single registered response slot and a completed-response counter.
module logic_op_arbiter
  import logic_op_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_A,
  input  logic [WIDTH-1:0] req0_B,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_A,
  input  logic [WIDTH-1:0] req1_B,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_Y,
  output logic [CNT_W-1:0] done_cnt
);

  slot_e            slot_q, slot_d;
  logic             prio;
  logic             slot_free, grant_valid, grant_id, accept;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_a, sel_b, unit_y;

  // Readys depend only on valids, slot state, rsp_ready, prio and rst.
  assign grant_valid = req0_valid | req1_valid;
  assign grant_id    = (req0_valid & req1_valid) ? prio : req1_valid;
  assign slot_free   = (slot_q == SLOT_EMPTY) | rsp_ready;
  assign accept      = grant_valid & slot_free & ~rst;
  assign req0_ready  = accept & ~grant_id;
  assign req1_ready  = accept & grant_id;
  assign rsp_valid   = (slot_q == SLOT_FULL);

  assign sel_op = grant_id ? req1_op : req0_op;
  assign sel_a  = grant_id ? req1_A  : req0_A;
  assign sel_b  = grant_id ? req1_B  : req0_B;

  logic_unit_8bit #(.WIDTH(WIDTH)) u_unit (
    .op (sel_op),
    .a  (sel_a),
    .b  (sel_b),
    .y  (unit_y)
  );

  always_comb begin
    slot_d = slot_q;
    if (accept) begin
      slot_d = SLOT_FULL;
    end else if (slot_q == SLOT_FULL && rsp_ready) begin
      slot_d = SLOT_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= SLOT_EMPTY;
    end else begin
      slot_q <= slot_d;
    end
  end

  // Priority flips to the other requester only when a grant is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_Y    <= '0;
      rsp_id   <= 1'b0;
      prio     <= 1'b0;
      done_cnt <= '0;
    end else begin
      if (accept) begin
        rsp_Y  <= unit_y;
        rsp_id <= grant_id;
        prio   <= ~grant_id;
      end
      if (rsp_valid && rsp_ready) begin
        done_cnt <= done_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Randomized and directed bench for logic_op_arbiter against a transaction-level model.
module tb_logic_op_arbiter;

  localparam int WIDTH = 8;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req0_ready, req1_valid, req1_ready;
  logic [1:0]       req0_op, req1_op;
  logic [WIDTH-1:0] req0_A, req0_B, req1_A, req1_B;
  logic             rsp_valid, rsp_ready, rsp_id;
  logic [WIDTH-1:0] rsp_Y;
  logic [CNT_W-1:0] done_cnt;

  int compared   = 0;
  int mismatched = 0;

  // Model: held response (present flag, value, id), next-winner pointer, completions.
  bit               hold_valid = 1'b0;
  logic [WIDTH-1:0] hold_y     = '0;
  bit               hold_id    = 1'b0;
  bit               turn       = 1'b0;
  int               completed  = 0;

  always #5 clk = ~clk;

  logic_op_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_A     (req0_A),
    .req0_B     (req0_B),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_A     (req1_A),
    .req1_B     (req1_B),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_Y      (rsp_Y),
    .done_cnt   (done_cnt)
  );

  function automatic logic [WIDTH-1:0] logicOp(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~(a ^ b);
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic v0, input logic [1:0] op0,
                               input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0,
                               input logic v1, input logic [1:0] op1,
                               input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1,
                               input logic rr);
    rst        = r;
    req0_valid = v0;  req0_op = op0;  req0_A = a0;  req0_B = b0;
    req1_valid = v1;  req1_op = op1;  req1_A = a1;  req1_B = b1;
    rsp_ready  = rr;
    #2;
  endtask

  // Checks readys before the edge, advances the model across it, checks registered outputs.
  task automatic clockEdge(output bit acc0, output bit acc1);
    bit               room, winner, take;
    logic [WIDTH-1:0] y;
    room   = !hold_valid || rsp_ready;
    winner = (req0_valid && req1_valid) ? turn : req1_valid;
    take   = !rst && room && (req0_valid || req1_valid);
    acc0   = take && !winner;
    acc1   = take && winner;
    y      = winner ? logicOp(req1_op, req1_A, req1_B) : logicOp(req0_op, req0_A, req0_B);
    checkOutput("req0_ready", 32'(req0_ready), 32'(acc0));
    checkOutput("req1_ready", 32'(req1_ready), 32'(acc1));
    if (rst) begin
      hold_valid = 1'b0; hold_y = '0; hold_id = 1'b0; turn = 1'b0; completed = 0;
    end else begin
      if (hold_valid && rsp_ready) begin
        completed++;
        hold_valid = 1'b0;
      end
      if (take) begin
        hold_valid = 1'b1; hold_y = y; hold_id = winner; turn = !winner;
      end
    end
    @(posedge clk);
    #1;
    checkOutput("rsp_valid", 32'(rsp_valid), 32'(hold_valid));
    checkOutput("rsp_Y", 32'(rsp_Y), 32'(hold_y));
    checkOutput("rsp_id", 32'(rsp_id), 32'(hold_id));
    checkOutput("done_cnt", 32'(done_cnt), 32'(completed % (1 << CNT_W)));
  endtask

  initial begin
    bit               a0, a1, p0v, p1v, rr;
    logic [1:0]       p0op, p1op;
    logic [WIDTH-1:0] p0a, p0b, p1a, p1b;
    logic [7:0]       sweep [4];
    int               guard;

    // Reset state
    applyStimulus(1, 1, 2'd0, 8'h00, 8'h00, 1, 2'd0, 8'h00, 8'h00, 1);
    checkOutput("reset_ready0", 32'(req0_ready), 'h0);
    checkOutput("reset_ready1", 32'(req1_ready), 'h0);
    clockEdge(a0, a1);
    applyStimulus(1, 0, 2'd0, 8'h00, 8'h00, 0, 2'd0, 8'h00, 8'h00, 1);
    clockEdge(a0, a1);
    checkOutput("reset_valid", 32'(rsp_valid), 'h0);
    checkOutput("reset_cnt", 32'(done_cnt), 'h0);

    // First op right after reset: req0 XNOR AA/55
    applyStimulus(0, 1, 2'd3, 8'hAA, 8'h55, 0, 2'd0, 8'h00, 8'h00, 1);
    checkOutput("first_ready0", 32'(req0_ready), 'h1);
    clockEdge(a0, a1);
    checkOutput("first_valid", 32'(rsp_valid), 'h1);
    checkOutput("first_Y", 32'(rsp_Y), 'h00);
    checkOutput("first_id", 32'(rsp_id), 'h0);
    applyStimulus(0, 0, 2'd0, 8'h00, 8'h00, 0, 2'd0, 8'h00, 8'h00, 1);
    clockEdge(a0, a1);
    checkOutput("first_cnt", 32'(done_cnt), 'h1);

    // Backpressure: req1 XOR 3C/C3 held while consumer stalls, req0 waiting
    applyStimulus(0, 0, 2'd0, 8'h00, 8'h00, 1, 2'd2, 8'h3C, 8'hC3, 1);
    clockEdge(a0, a1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 2'd1, 8'h01, 8'h02, 0, 2'd0, 8'h00, 8'h00, 0);
      checkOutput("stall_ready0", 32'(req0_ready), 'h0);
      checkOutput("stall_ready1", 32'(req1_ready), 'h0);
      clockEdge(a0, a1);
      checkOutput("stall_Y", 32'(rsp_Y), 'hFF);
      checkOutput("stall_id", 32'(rsp_id), 'h1);
    end
    applyStimulus(0, 1, 2'd1, 8'h01, 8'h02, 0, 2'd0, 8'h00, 8'h00, 1);
    checkOutput("unstall_ready0", 32'(req0_ready), 'h1);
    clockEdge(a0, a1);
    checkOutput("unstall_Y", 32'(rsp_Y), 'h03);

    // Opcode sweep on req1 with A=12, B=21
    sweep[0] = 8'h00; sweep[1] = 8'h33; sweep[2] = 8'h33; sweep[3] = 8'hCC;
    for (int op = 0; op < 4; op++) begin
      applyStimulus(0, 0, 2'd0, 8'h00, 8'h00, 1, 2'(op), 8'h12, 8'h21, 1);
      clockEdge(a0, a1);
      checkOutput($sformatf("sweep_op%0d", op), 32'(rsp_Y), 32'(sweep[op]));
    end

    // Reset while FULL and stalled
    applyStimulus(0, 0, 2'd0, 8'h00, 8'h00, 1, 2'd1, 8'h5A, 8'h00, 0);
    clockEdge(a0, a1);
    applyStimulus(1, 1, 2'd0, 8'hFF, 8'hFF, 1, 2'd0, 8'hFF, 8'hFF, 0);
    checkOutput("midrst_ready0", 32'(req0_ready), 'h0);
    checkOutput("midrst_ready1", 32'(req1_ready), 'h0);
    clockEdge(a0, a1);
    checkOutput("midrst_valid", 32'(rsp_valid), 'h0);
    checkOutput("midrst_cnt", 32'(done_cnt), 'h0);

    // Both requesters always valid: strict alternation starting with req0
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 2'd3, 8'hF0, 8'hF0, 1, 2'd0, 8'h0F, 8'hF0, 1);
      clockEdge(a0, a1);
      checkOutput($sformatf("alt_id%0d", i), 32'(rsp_id), 32'(i % 2));
      checkOutput($sformatf("alt_Y%0d", i), 32'(rsp_Y), (i % 2) ? 'h00 : 'hFF);
    end

    // Random traffic; requesters hold payload until accepted
    p0v = 0; p1v = 0;
    p0op = '0; p1op = '0; p0a = '0; p0b = '0; p1a = '0; p1b = '0;
    for (int i = 0; i < 400; i++) begin
      if (!p0v && $urandom_range(0, 1) == 1) begin
        p0v = 1; p0op = 2'($urandom); p0a = 8'($urandom); p0b = 8'($urandom);
      end
      if (!p1v && $urandom_range(0, 1) == 1) begin
        p1v = 1; p1op = 2'($urandom); p1a = 8'($urandom); p1b = 8'($urandom);
      end
      rr = ($urandom_range(0, 3) != 0);
      applyStimulus(0, p0v, p0op, p0a, p0b, p1v, p1op, p1a, p1b, rr);
      clockEdge(a0, a1);
      if (a0) p0v = 0;
      if (a1) p1v = 0;
    end

    // Counter wrap after exactly 256 completions
    applyStimulus(1, 0, 2'd0, 8'h00, 8'h00, 0, 2'd0, 8'h00, 8'h00, 1);
    clockEdge(a0, a1);
    guard = 0;
    while (completed < 256 && guard < 400) begin
      applyStimulus(0, 1, 2'($urandom), 8'($urandom), 8'($urandom), 0, 2'd0, 8'h00, 8'h00, 1);
      clockEdge(a0, a1);
      guard++;
    end
    if (completed < 256) checkOutput("wrap_timeout", 32'(completed), 256);
    checkOutput("wrap_cnt", 32'(done_cnt), 'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
